// File: rtl/rx_deser_n.sv
`default_nettype none
// ============================================================================
// Module   : rx_deser_n
// Brief    : UART RX deserializer with configurable width, bit order and parity.
// Revision : 1.0 - initial release
// ============================================================================
module rx_deser_n #(
    parameter int DATA_WIDTH = 8,   // legal range 5..9
    parameter int EDGE_W     = 5,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en_deser,
    input  logic [EDGE_W-1:0]     i_edge_cnt,
    input  logic [EDGE_W-1:0]     i_prescale,
    input  logic                  i_sampled_bit,
    input  logic                  i_frame_start,
    input  logic                  i_abort,
    input  logic                  i_par_en,
    input  logic                  i_par_odd,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    output logic                  o_par_err,
    output logic                  o_busy,
    output logic [3:0]            o_bit_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(DATA_WIDTH - 1);
    localparam logic [3:0] FULL_CNT = 4'(DATA_WIDTH);

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] sr, sr_next, shifted;
    logic [DATA_WIDTH-1:0] data_next;
    logic [3:0]            cnt_next;
    logic                  par_en, par_en_next;
    logic                  par_odd, par_odd_next;
    logic                  par_err_next, valid_next;
    logic [EDGE_W-1:0]     cap_edge;
    logic                  cap;

    // Wrapping subtraction makes prescale 0 capture on the last edge index.
    assign cap_edge = i_prescale - EDGE_W'(1);
    assign cap      = i_en_deser && (i_edge_cnt == cap_edge);

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shifted = {sr[DATA_WIDTH-2:0], i_sampled_bit};
        end else begin : g_lsb_first
            assign shifted = {i_sampled_bit, sr[DATA_WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            sr           <= '0;
            o_bit_cnt    <= '0;
            par_en       <= 1'b0;
            par_odd      <= 1'b0;
            o_data       <= '0;
            o_par_err    <= 1'b0;
            o_data_valid <= 1'b0;
        end else begin
            state        <= state_next;
            sr           <= sr_next;
            o_bit_cnt    <= cnt_next;
            par_en       <= par_en_next;
            par_odd      <= par_odd_next;
            o_data       <= data_next;
            o_par_err    <= par_err_next;
            o_data_valid <= valid_next;
        end
    end

    always_comb begin
        state_next   = state;
        sr_next      = sr;
        cnt_next     = o_bit_cnt;
        par_en_next  = par_en;
        par_odd_next = par_odd;
        data_next    = o_data;
        par_err_next = o_par_err;
        valid_next   = 1'b0;

        if (i_abort) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if (i_frame_start) begin
            // Restart wins over a completing capture in the same cycle.
            state_next   = DATA;
            sr_next      = '0;
            cnt_next     = '0;
            par_en_next  = i_par_en;
            par_odd_next = i_par_odd;
        end else if (cap) begin
            case (state)
                DATA: begin
                    sr_next = shifted;
                    if (o_bit_cnt == LAST_IDX) begin
                        if (par_en) begin
                            state_next = PARITY;
                            cnt_next   = FULL_CNT;
                        end else begin
                            state_next   = IDLE;
                            cnt_next     = '0;
                            data_next    = shifted;
                            par_err_next = 1'b0;
                            valid_next   = 1'b1;
                        end
                    end else begin
                        cnt_next = o_bit_cnt + 4'd1;
                    end
                end
                PARITY: begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    data_next    = sr;
                    par_err_next = i_sampled_bit ^ ((^sr) ^ par_odd);
                    valid_next   = 1'b1;
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    assign o_busy = (state == DATA) || (state == PARITY);

endmodule
`default_nettype wire

// File: tb/tb_rx_deser_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_deser_n
// Brief    : Scoreboard bench for rx_deser_n over three parameter sets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_deser_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_deser = 1'b1;
    logic [4:0] edge_cnt = '0;
    logic [4:0] prescale = 5'd8;
    logic       sampled = 1'b0;
    logic       fs = 1'b0;
    logic       abort = 1'b0;
    logic       par_en = 1'b0;
    logic       par_odd = 1'b0;
    logic [1:0] sel = 2'd0;

    logic       fs_a, fs_b, fs_c;
    logic [7:0] data_a, data_b;
    logic [4:0] data_c;
    logic       valid_a, valid_b, valid_c, perr_a, perr_b, perr_c;
    logic       busy_a, busy_b, busy_c;
    logic [3:0] cnt_a, cnt_b, cnt_c;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [8:0] d;
        logic       e;
    } exp_t;
    exp_t q_a[$], q_b[$], q_c[$];

    assign fs_a = fs && (sel == 2'd0);
    assign fs_b = fs && (sel == 2'd1);
    assign fs_c = fs && (sel == 2'd2);

    always #5 clk = ~clk;

    rx_deser_n #(.DATA_WIDTH(8), .EDGE_W(5), .MSB_FIRST(1'b0)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en_deser(en_deser), .i_edge_cnt(edge_cnt),
        .i_prescale(prescale), .i_sampled_bit(sampled), .i_frame_start(fs_a),
        .i_abort(abort), .i_par_en(par_en), .i_par_odd(par_odd),
        .o_data(data_a), .o_data_valid(valid_a), .o_par_err(perr_a),
        .o_busy(busy_a), .o_bit_cnt(cnt_a));

    rx_deser_n #(.DATA_WIDTH(8), .EDGE_W(5), .MSB_FIRST(1'b1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en_deser(en_deser), .i_edge_cnt(edge_cnt),
        .i_prescale(prescale), .i_sampled_bit(sampled), .i_frame_start(fs_b),
        .i_abort(abort), .i_par_en(par_en), .i_par_odd(par_odd),
        .o_data(data_b), .o_data_valid(valid_b), .o_par_err(perr_b),
        .o_busy(busy_b), .o_bit_cnt(cnt_b));

    rx_deser_n #(.DATA_WIDTH(5), .EDGE_W(5), .MSB_FIRST(1'b0)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_en_deser(en_deser), .i_edge_cnt(edge_cnt),
        .i_prescale(prescale), .i_sampled_bit(sampled), .i_frame_start(fs_c),
        .i_abort(abort), .i_par_en(par_en), .i_par_odd(par_odd),
        .o_data(data_c), .o_data_valid(valid_c), .o_par_err(perr_c),
        .o_busy(busy_c), .o_bit_cnt(cnt_c));

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input string name, inout exp_t q[$], input logic [8:0] d, input logic e);
        exp_t x;
        vectors++;
        if (q.size() == 0) begin
            miscompares++;
            $display("FAIL %s unexpected strobe: got data %0h err %0b, expected none", name, d, e);
        end else begin
            x = q.pop_front();
            if (x.d !== d || x.e !== e) begin
                miscompares++;
                $display("FAIL %s strobe: got data %0h err %0b, expected data %0h err %0b",
                         name, d, e, x.d, x.e);
            end
        end
    endtask

    // Monitor: compares every strobe against the head of its scoreboard queue.
    always @(posedge clk) begin
        #2;
        if (valid_a) sb_pop("dut_a", q_a, {1'b0, data_a}, perr_a);
        if (valid_b) sb_pop("dut_b", q_b, {1'b0, data_b}, perr_b);
        if (valid_c) sb_pop("dut_c", q_c, {4'b0, data_c}, perr_c);
    end

    task automatic quiet();
        @(negedge clk);
        edge_cnt = '0;
        en_deser = 1'b1;
        fs       = 1'b0;
        abort    = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic start(input logic [1:0] which, input logic pen, input logic podd);
        @(negedge clk);
        sel = which; edge_cnt = '0; fs = 1'b1; par_en = pen; par_odd = podd;
        @(negedge clk);
        fs = 1'b0;
        // Mid-frame changes must be ignored.
        par_en = ~pen; par_odd = ~podd;
    endtask

    task automatic send_bit(input logic b, input logic en_cap, input logic fs_cap);
        int n;
        n = (prescale == 5'd0) ? 32 : int'(prescale);
        for (int e = 0; e < n; e++) begin
            @(negedge clk);
            edge_cnt = 5'(e);
            sampled  = b;
            en_deser = (e == n - 1) ? en_cap : 1'b1;
            fs       = (e == n - 1) ? fs_cap : 1'b0;
        end
    endtask

    task automatic send_word(input logic [8:0] d, input int w, input logic msb, input int nbits);
        for (int i = 0; i < nbits; i++)
            send_bit(msb ? d[w-1-i] : d[i], 1'b1, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        quiet();
        check("reset data", {8'b0, data_a}, 16'h0);
        check("reset valid", {15'b0, valid_a}, 16'h0);
        check("reset par_err", {15'b0, perr_a}, 16'h0);
        check("reset busy", {15'b0, busy_a}, 16'h0);
        check("reset bit_cnt", {12'b0, cnt_a}, 16'h0);

        // LSB-first 0xA5, no parity.
        prescale = 5'd8;
        q_a.push_back('{d: 9'h0A5, e: 1'b0});
        start(2'd0, 1'b0, 1'b0);
        check("busy after start", {15'b0, busy_a}, 16'h1);
        send_word(9'h0A5, 8, 1'b0, 8);
        quiet();
        check("A5 valid latency", {15'b0, valid_a}, 16'h1);
        check("A5 busy falls", {15'b0, busy_a}, 16'h0);
        check("A5 bit_cnt", {12'b0, cnt_a}, 16'h0);

        // MSB-first instance, stream 1,0,1,0,0,1,0,1.
        q_b.push_back('{d: 9'h0A5, e: 1'b0});
        start(2'd1, 1'b0, 1'b0);
        send_word(9'h0A5, 8, 1'b1, 8);
        quiet();

        // Even parity 0x03 with parity bit 0, then 1.
        q_a.push_back('{d: 9'h003, e: 1'b0});
        start(2'd0, 1'b1, 1'b0);
        send_word(9'h003, 8, 1'b0, 8);
        quiet();
        check("parity state bit_cnt", {12'b0, cnt_a}, 16'h8);
        check("parity state busy", {15'b0, busy_a}, 16'h1);
        send_bit(1'b0, 1'b1, 1'b0);
        quiet();
        q_a.push_back('{d: 9'h003, e: 1'b1});
        start(2'd0, 1'b1, 1'b0);
        send_word(9'h003, 8, 1'b0, 8);
        send_bit(1'b1, 1'b1, 1'b0);
        quiet();

        // Odd parity 0x03 with parity bit 1, prescale 0 (capture at edge 31).
        prescale = 5'd0;
        q_a.push_back('{d: 9'h003, e: 1'b0});
        start(2'd0, 1'b1, 1'b1);
        send_word(9'h003, 8, 1'b0, 8);
        send_bit(1'b1, 1'b1, 1'b0);
        quiet();
        prescale = 5'd8;

        // Complete 0x5A, then abort after 4 caps.
        q_a.push_back('{d: 9'h05A, e: 1'b0});
        start(2'd0, 1'b0, 1'b0);
        send_word(9'h05A, 8, 1'b0, 8);
        quiet();
        start(2'd0, 1'b0, 1'b0);
        send_word(9'h0FF, 8, 1'b0, 4);
        @(negedge clk);
        edge_cnt = '0; abort = 1'b1;
        quiet();
        check("abort busy", {15'b0, busy_a}, 16'h0);
        check("abort bit_cnt", {12'b0, cnt_a}, 16'h0);
        check("abort data held", {8'b0, data_a}, 16'h005A);

        // Restart after 3 caps, then 0x3C with a gated-off bit inserted.
        q_a.push_back('{d: 9'h03C, e: 1'b0});
        start(2'd0, 1'b0, 1'b0);
        send_word(9'h1FF, 8, 1'b0, 3);
        start(2'd0, 1'b0, 1'b0);
        check("restart bit_cnt", {12'b0, cnt_a}, 16'h0);
        send_word(9'h03C, 8, 1'b0, 2);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        quiet();
        check("3C data", {8'b0, data_a}, 16'h003C);

        // Frame start on the completing cap drops the old frame.
        start(2'd0, 1'b0, 1'b0);
        send_word(9'h0FF, 8, 1'b0, 7);
        send_bit(1'b1, 1'b1, 1'b1);
        quiet();
        check("restart-on-cap busy", {15'b0, busy_a}, 16'h1);
        check("restart-on-cap bit_cnt", {12'b0, cnt_a}, 16'h0);
        q_a.push_back('{d: 9'h081, e: 1'b0});
        send_word(9'h081, 8, 1'b0, 8);
        quiet();

        // Width 5, prescale 16, reset mid-frame then 0x15.
        prescale = 5'd16;
        start(2'd2, 1'b0, 1'b0);
        send_word(9'h01F, 5, 1'b0, 2);
        @(negedge clk);
        edge_cnt = '0; rst = 1'b1;
        quiet();
        check("w5 reset data", {11'b0, data_c}, 16'h0);
        check("w5 reset valid", {15'b0, valid_c}, 16'h0);
        check("w5 reset busy", {15'b0, busy_c}, 16'h0);
        check("w5 reset bit_cnt", {12'b0, cnt_c}, 16'h0);
        check("w5 reset par_err", {15'b0, perr_c}, 16'h0);
        q_c.push_back('{d: 9'h015, e: 1'b0});
        start(2'd2, 1'b0, 1'b0);
        send_word(9'h015, 5, 1'b0, 5);
        quiet();
        check("w5 data", {11'b0, data_c}, 16'h0015);

        repeat (5) @(negedge clk);
        check("dut_a missing strobes", 16'(q_a.size()), 16'h0);
        check("dut_b missing strobes", 16'(q_b.size()), 16'h0);
        check("dut_c missing strobes", 16'(q_c.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
